bit_select_xbar: RTL and testbench

Runtime-programmable bit crossbar with a registered, valid/ready output stage. Each output bit selects any input bit or a constant 0/1, according to a mapping table that holds several contexts; every data beat picks its context. The block generalises fixed array-select wiring between instance ports into a parametrised, reconfigurable, pipelined stage that sits between producer and consumer instances in generated netlists.

---
 rtl/bit_select_pkg.sv | 21 ++
 rtl/bit_select_mux.sv | 20 ++
 rtl/bit_select_xbar.sv | 75 +++++++
 tb/tb_bit_select_xbar.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bit_select_pkg.sv
// bit_select_pkg: width derivations, selector constants and table init shared by the crossbar files.
package bit_select_pkg;
    function automatic int selw_f(input int width);
        return $clog2(width + 2);
    endfunction
    function automatic int ctxw_f(input int nctx);
        return (nctx > 1) ? $clog2(nctx) : 1;
    endfunction
    function automatic int idxw_f(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction
    function automatic int sel_zero(input int width);
        return width;
    endfunction
    function automatic int sel_one(input int width);
        return width + 1;
    endfunction
    function automatic int ident_sel(input int i);
        return i;
    endfunction
endpackage

// File: rtl/bit_select_mux.sv
// bit_select_mux: maps one data word through a single context row; selectors past WIDTH give constants.
module bit_select_mux
    import bit_select_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SELW  = selw_f(WIDTH)
) (
    input  logic [WIDTH-1:0][SELW-1:0] row,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           mapped
);
    localparam int IDXW = idxw_f(WIDTH);
    localparam logic [SELW-1:0] S_ZERO = SELW'(sel_zero(WIDTH));
    localparam logic [SELW-1:0] S_ONE  = SELW'(sel_one(WIDTH));
    always_comb begin
        mapped = '0;
        for (int i = 0; i < WIDTH; i++)
            mapped[i] = (row[i] < S_ZERO) ? data[row[i][IDXW-1:0]] : (row[i] == S_ONE);
    end
endmodule

// File: rtl/bit_select_xbar.sv
// bit_select_xbar: multi-context programmable bit crossbar with a registered valid/ready output stage.
module bit_select_xbar
    import bit_select_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NCTX  = 2,
    parameter int SELW  = selw_f(WIDTH),
    parameter int CTXW  = ctxw_f(NCTX),
    parameter int IDXW  = idxw_f(WIDTH)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cfg_we,
    input  logic [CTXW-1:0]  cfg_ctx,
    input  logic [IDXW-1:0]  cfg_idx,
    input  logic [SELW-1:0]  cfg_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CTXW-1:0]  in_ctx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      beat_count
);
    localparam logic [CTXW:0] NCTX_L  = (CTXW + 1)'(NCTX);
    localparam logic [IDXW:0] WIDTH_L = (IDXW + 1)'(WIDTH);

    logic [NCTX-1:0][WIDTH-1:0][SELW-1:0] map_q, map_d;
    logic [WIDTH-1:0][SELW-1:0] row;
    logic [WIDTH-1:0] mapped, out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d, accept, ctx_ok;
    logic [15:0]      beat_count_q, beat_count_d;

    assign ctx_ok = {1'b0, in_ctx} < NCTX_L;
    assign row    = map_q[in_ctx];

    bit_select_mux #(.WIDTH(WIDTH), .SELW(SELW)) u_mux (
        .row    (row),
        .data   (in_data),
        .mapped (mapped)
    );

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign beat_count = beat_count_q;

    always_comb begin
        map_d = map_q;
        if (cfg_we && ({1'b0, cfg_ctx} < NCTX_L) && ({1'b0, cfg_idx} < WIDTH_L))
            map_d[cfg_ctx][cfg_idx] = cfg_sel;
        // Unknown contexts still consume the beat but deliver zeros.
        out_data_d   = accept ? (ctx_ok ? mapped : '0) : out_data_q;
        out_valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        beat_count_d = beat_count_q + 16'(out_valid_q && out_ready);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < NCTX; c++)
                for (int i = 0; i < WIDTH; i++)
                    map_q[c][i] <= SELW'(ident_sel(i));
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            beat_count_q <= '0;
        end else begin
            map_q        <= map_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            beat_count_q <= beat_count_d;
        end
    end
endmodule

// File: tb/tb_bit_select_xbar.sv
// tb_bit_select_xbar: directed checks of mapping, constants, handshake, reset and counter wrap.
module tb_bit_select_xbar;
    logic       clk = 0, arst_n = 0;
    logic       cfg_we = 0;
    logic [1:0] cfg_ctx = 0, cfg_idx = 0, in_ctx = 0;
    logic [2:0] cfg_sel = 0;
    logic       in_valid = 0, out_ready = 0;
    logic       in_ready, out_valid;
    logic [3:0] in_data = 0, out_data;
    logic [15:0] beat_count;
    int total = 0, bad = 0;

    bit_select_xbar #(.WIDTH(4), .NCTX(3)) dut (
        .clk(clk), .arst_n(arst_n), .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_idx(cfg_idx),
        .cfg_sel(cfg_sel), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ctx(in_ctx), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] c, input logic [1:0] i, input logic [2:0] s);
        cfg_we = 1; cfg_ctx = c; cfg_idx = i; cfg_sel = s;
        step();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 4'b0) begin bad++; $display("FAIL reset_data got=%b want=0000", out_data); end
        total++; if (beat_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", beat_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        step();
        arst_n = 1;
    endtask

    task automatic test_identity();
        out_ready = 1; in_valid = 1; in_data = 4'b1010; in_ctx = 0;
        step();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_data !== 4'b1010) begin bad++; $display("FAIL ident_data got=%b/%b want=1/1010", out_valid, out_data); end
        step();
        total++; if (beat_count !== 16'd1 || out_valid !== 1'b0) begin bad++; $display("FAIL ident_count got=%0d/%b want=1/0", beat_count, out_valid); end
    endtask

    task automatic test_program();
        cfg_write(1, 3, 2); cfg_write(1, 2, 1); cfg_write(1, 1, 0); cfg_write(1, 0, 0);
        in_valid = 1; in_data = 4'b0101; in_ctx = 1;
        step();
        total++; if (out_data !== 4'b1011) begin bad++; $display("FAIL prog_ctx1 got=%b want=1011", out_data); end
        in_data = 4'b0110; in_ctx = 0;
        step();
        total++; if (out_data !== 4'b0110) begin bad++; $display("FAIL prog_ctx0 got=%b want=0110", out_data); end
        in_valid = 0;
        step();
    endtask

    task automatic test_constants();
        cfg_write(0, 3, 5); cfg_write(0, 2, 4); cfg_write(0, 1, 7); cfg_write(0, 0, 3);
        cfg_write(3, 1, 5);
        in_valid = 1; in_data = 4'b1000; in_ctx = 0;
        step();
        total++; if (out_data !== 4'b1001) begin bad++; $display("FAIL const_sel got=%b want=1001", out_data); end
        in_data = 4'b1111; in_ctx = 3;
        step();
        total++; if (out_data !== 4'b0000 || out_valid !== 1'b1) begin bad++; $display("FAIL bad_ctx got=%b/%b want=1/0000", out_valid, out_data); end
        in_data = 4'b0110; in_ctx = 0;
        step();
        total++; if (out_data !== 4'b1000) begin bad++; $display("FAIL const_after_badwr got=%b want=1000", out_data); end
        in_valid = 0;
        step();
    endtask

    task automatic test_same_cycle();
        cfg_write(0, 3, 3); cfg_write(0, 2, 2); cfg_write(0, 1, 1); cfg_write(0, 0, 0);
        cfg_we = 1; cfg_ctx = 0; cfg_idx = 0; cfg_sel = 5;
        in_valid = 1; in_data = 4'b0000; in_ctx = 0;
        step();
        cfg_we = 0;
        total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL same_cycle_old got=%b want=0000", out_data); end
        step();
        total++; if (out_data !== 4'b0001) begin bad++; $display("FAIL same_cycle_new got=%b want=0001", out_data); end
        in_valid = 0;
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] c0;
        c0 = beat_count;
        out_ready = 0; in_valid = 1; in_data = 4'b1010; in_ctx = 0;
        step();
        in_data = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'b1011 || beat_count !== c0) begin
                bad++; $display("FAIL stall_%0d got=r%b v%b d%b c%0d want=r0 v1 d1011 c%0d", k, in_ready, out_valid, out_data, beat_count, c0);
            end
            step();
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", in_ready); end
        step();
        total++; if (out_data !== 4'b0101 || beat_count !== c0 + 16'd1) begin bad++; $display("FAIL release_xfer got=%b/%0d want=0101/%0d", out_data, beat_count, c0 + 16'd1); end
        in_data = 4'b0010;
        step();
        total++; if (out_data !== 4'b0011 || beat_count !== c0 + 16'd2) begin bad++; $display("FAIL stream got=%b/%0d want=0011/%0d", out_data, beat_count, c0 + 16'd2); end
        in_valid = 0;
        step();
        total++; if (out_valid !== 1'b0 || beat_count !== c0 + 16'd3) begin bad++; $display("FAIL drain got=%b/%0d want=0/%0d", out_valid, beat_count, c0 + 16'd3); end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_data = 4'b1100; in_ctx = 1;
        step();
        arst_n = 0;
        #1;
        total++; if (out_valid !== 1'b0 || beat_count !== 16'd0 || out_data !== 4'b0) begin bad++; $display("FAIL mid_reset got=%b/%0d/%b want=0/0/0000", out_valid, beat_count, out_data); end
        in_valid = 0;
        step();
        arst_n = 1; out_ready = 1; in_valid = 1;
        step();
        total++; if (out_data !== 4'b1100) begin bad++; $display("FAIL post_reset_ctx1 got=%b want=1100", out_data); end
        in_data = 4'b0000; in_ctx = 0;
        step();
        total++; if (out_data !== 4'b0000) begin bad++; $display("FAIL post_reset_ctx0 got=%b want=0000", out_data); end
        in_valid = 0;
        step();
    endtask

    task automatic test_wrap();
        arst_n = 0;
        step();
        arst_n = 1; out_ready = 1; in_valid = 1; in_data = 4'b0110; in_ctx = 0;
        for (int k = 0; k < 65536; k++) step();
        total++; if (beat_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", beat_count); end
        step();
        total++; if (beat_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", beat_count); end
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_program();
        test_constants();
        test_same_cycle();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
